// File: rtl/huff_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | huff_pkg : Huffman code table, escape constants and packer FSM states     |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package huff_pkg;

   localparam int MAX_LEN_MIN = 14;
   localparam int CODE_W      = 14;
   localparam int LEN_W       = 5;
   localparam int NUM_SYM     = 27;
   localparam logic [4:0] SPACE_IDX = 5'd26;

   localparam logic [5:0] ESC_CODE = 6'b000000;
   localparam int         ESC_LEN  = 6;

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [CODE_W-1:0] code;
   } code_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      LAST  = 2'd2
   } state_t;

   // Index 0..25 = 'a'..'z', 26 = space; codes are right-aligned in CODE_W bits.
   localparam code_t CODE_TAB [NUM_SYM] = '{
      '{5'd4,  14'b1100},           // a
      '{5'd6,  14'b000011},         // b
      '{5'd5,  14'b00111},          // c
      '{5'd5,  14'b00101},          // d
      '{5'd4,  14'b0110},           // e
      '{5'd5,  14'b01011},          // f
      '{5'd5,  14'b00010},          // g
      '{5'd4,  14'b1011},           // h
      '{5'd4,  14'b1000},           // i
      '{5'd9,  14'b000001110},      // j
      '{5'd8,  14'b00000110},       // k
      '{5'd5,  14'b00110},          // l
      '{5'd5,  14'b01001},          // m
      '{5'd4,  14'b1001},           // n
      '{5'd4,  14'b1101},           // o
      '{5'd6,  14'b000010},         // p
      '{5'd11, 14'b00000111110},    // q
      '{5'd5,  14'b00100},          // r
      '{5'd4,  14'b1010},           // s
      '{5'd4,  14'b0111},           // t
      '{5'd5,  14'b01000},          // u
      '{5'd7,  14'b0000010},        // v
      '{5'd5,  14'b01010},          // w
      '{5'd10, 14'b0000011110},     // x
      '{5'd5,  14'b00011},          // y
      '{5'd11, 14'b00000111111},    // z
      '{5'd3,  14'b111}             // space
   };

endpackage
`default_nettype wire

// File: rtl/huffman_packer_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | huffman_packer_if : symbol input, packed word output and status signals   |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface huffman_packer_if #(
   parameter int OUT_W = 32
);
   localparam int OB_W = $clog2(OUT_W + 1);

   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [OB_W-1:0]  out_bits;
   logic             err_sym;
   logic [31:0]      bit_count;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_bits, err_sym, bit_count
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid, out_last, out_bits, err_sym, bit_count
   );
endinterface
`default_nettype wire

// File: rtl/huff_code_lut.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | huff_code_lut : symbol -> code/length; HUFF_ESCAPE_EN escapes unmapped    |
// | symbols as prefix + 8 raw bits, otherwise they get length 0. rev 1.0      |
// +---------------------------------------------------------------------------+
module huff_code_lut
   import huff_pkg::*;
(
   input  logic [7:0]        sym,
   output logic [CODE_W-1:0] code,
   output logic [LEN_W-1:0]  len,
   output logic              unmapped
);

   code_t      ent;
   logic [4:0] idx;

   always_comb begin
      ent      = '0;
      idx      = 5'(sym - 8'h61);
      unmapped = 1'b0;
      if (sym >= 8'h61 && sym <= 8'h7A) begin
         ent = CODE_TAB[idx];
      end else if (sym == 8'h20) begin
         ent = CODE_TAB[SPACE_IDX];
      end else begin
         unmapped = 1'b1;
`ifdef HUFF_ESCAPE_EN
         ent.len  = LEN_W'(ESC_LEN + 8);
         ent.code = CODE_W'({ESC_CODE, sym});
`endif
      end
   end

   assign code = ent.code;
   assign len  = ent.len;

endmodule
`default_nettype wire

// File: rtl/huffman_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | huffman_packer : packs variable-length codes MSB-first into OUT_W words   |
// | (escape handling set by HUFF_ESCAPE_EN in huff_code_lut). rev 1.0         |
// +---------------------------------------------------------------------------+
module huffman_packer
   import huff_pkg::*;
#(
   parameter int OUT_W   = 32,
   parameter int MAX_LEN = 14
)(
   input logic             clk,
   input logic             rst,
   huffman_packer_if.slave bus
);

   localparam int ACC_W  = OUT_W + MAX_LEN;
   localparam int FILL_W = $clog2(ACC_W);
   localparam int OB_W   = $clog2(OUT_W + 1);
   localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  acc, acc_nxt, acc_shift, code_ext;
   logic [FILL_W-1:0] fill, fill_nxt;
   logic [CODE_W-1:0] code;
   logic [LEN_W-1:0]  len;
   logic              unmapped;
   logic              sym_fire, word_fire;
   logic              err_pulse;
   logic [31:0]       bits_total;
   int                base_fill;

   huff_code_lut u_lut (
      .sym      (bus.in_data),
      .code     (code),
      .len      (len),
      .unmapped (unmapped)
   );

   assign bus.in_ready  = (state == RUN) && (fill < OUT_W_F);
   assign sym_fire      = bus.in_valid && bus.in_ready;
   assign word_fire     = bus.out_valid && bus.out_ready;
   assign bus.err_sym   = err_pulse;
   assign bus.bit_count = bits_total;

   // Unfilled accumulator bits are always zero, so the top slice doubles as padded last word.
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_bits  = '0;
      bus.out_data  = acc[ACC_W-1 -: OUT_W];
      case (state)
         RUN, FLUSH: begin
            if (fill >= OUT_W_F) begin
               bus.out_valid = 1'b1;
               bus.out_bits  = OB_W'(OUT_W);
            end
         end
         LAST: begin
            bus.out_valid = 1'b1;
            bus.out_last  = 1'b1;
            bus.out_bits  = OB_W'(fill);
         end
         default: ;
      endcase
   end

   always_comb begin
      acc_shift = word_fire ? (acc << OUT_W) : acc;
      base_fill = word_fire ? int'(fill) - OUT_W : int'(fill);
      code_ext  = ACC_W'(code);
      acc_nxt   = acc_shift;
      fill_nxt  = FILL_W'(base_fill);
      if (sym_fire) begin
         acc_nxt  = acc_shift | (code_ext << (ACC_W - base_fill - int'(len)));
         fill_nxt = FILL_W'(base_fill + int'(len));
      end
      if (state == LAST && word_fire) begin
         acc_nxt  = '0;
         fill_nxt = '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (bus.flush)       state_nxt = FLUSH;
         FLUSH:   if (fill < OUT_W_F)  state_nxt = LAST;
         LAST:    if (word_fire)       state_nxt = RUN;
         default:                      state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         acc        <= '0;
         fill       <= '0;
         err_pulse  <= 1'b0;
         bits_total <= '0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         fill      <= fill_nxt;
         err_pulse <= sym_fire && unmapped;
         if (sym_fire) begin
            bits_total <= bits_total + 32'(len);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_huffman_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_huffman_packer : directed vectors with queue scoreboard, OUT_W = 8     |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_huffman_packer;

   localparam int OUT_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   huffman_packer_if #(.OUT_W(OUT_W)) bus ();

   huffman_packer #(.OUT_W(OUT_W), .MAX_LEN(14)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] bits;
      logic       last;
   } word_t;

   word_t exp_q[$];
   word_t mon_w;
   int    compared    = 0;
   int    mismatched  = 0;
   logic  sender_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [7:0] d, input logic [3:0] b, input logic l);
      exp_q.push_back({d, b, l});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] s);
      int n = 0;
      bus.in_data  = s;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 300) begin
         tick();
         n++;
      end
      if (!bus.in_ready) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout: in_ready got 0, want 1 for symbol 0x%0h", s);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: got %0d words outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      tick();
      tick();
   endtask

   // Monitor: every word the DUT hands over must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_word: got data=0x%0h bits=%0d last=%0b, want no word",
                     bus.out_data, bus.out_bits, bus.out_last);
         end else begin
            mon_w = exp_q.pop_front();
            chk("word_data", 32'(bus.out_data), 32'(mon_w.data));
            chk("word_bits", 32'(bus.out_bits), 32'(mon_w.bits));
            chk("word_last", 32'(bus.out_last), 32'(mon_w.last));
         end
      end
   end

   initial begin
      int n;
      logic [31:0] exp_bc;
      bus.in_data   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_last",  32'(bus.out_last),  32'd0);
      chk("rst_out_bits",  32'(bus.out_bits),  32'd0);
      chk("rst_err_sym",   32'(bus.err_sym),   32'd0);
      chk("rst_bit_count", bus.bit_count,      32'd0);
      rst = 1'b0;

      // Eight spaces: 24 one-bits, three full words.
      repeat (3) expect_word(8'hFF, 4'd8, 1'b0);
      for (int i = 0; i < 8; i++) send(8'h20);
      drain();
      chk("bit_count_spaces", bus.bit_count, 32'd24);

      // "e" + space + flush: 0110 111 -> 0x6E, 7 bits.
      expect_word(8'h6E, 4'd7, 1'b1);
      send(8'h65);
      chk("err_sym_mapped", 32'(bus.err_sym), 32'd0);
      send(8'h20);
      do_flush();
      drain();
      chk("bit_count_e_sp", bus.bit_count, 32'd31);

      // Flush of an empty accumulator.
      expect_word(8'h00, 4'd0, 1'b1);
      do_flush();
      drain();
      chk("bit_count_empty", bus.bit_count, 32'd31);

      // "hiz": 1011 1000 | 0000 0111 | 111 -> B8, 07, E0/3; z straddles a word boundary.
      expect_word(8'hB8, 4'd8, 1'b0);
      expect_word(8'h07, 4'd8, 1'b0);
      expect_word(8'hE0, 4'd3, 1'b1);
      send(8'h68);
      send(8'h69);
      send(8'h7A);
      do_flush();
      drain();
      chk("bit_count_hiz", bus.bit_count, 32'd50);

      // Back-pressure: "at" x6 (0xC7 per pair) with out_ready low for 20 cycles.
      repeat (6) expect_word(8'hC7, 4'd8, 1'b0);
      expect_word(8'h00, 4'd0, 1'b1);
      bus.out_ready = 1'b0;
      sender_done   = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               send(8'h61);
               send(8'h74);
            end
            sender_done = 1'b1;
         end
      join_none
      repeat (20) tick();
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_data",  32'(bus.out_data),  32'hC7);
      bus.out_ready = 1'b1;
      n = 0;
      while (!sender_done && n < 400) begin
         tick();
         n++;
      end
      if (!sender_done) begin
         compared++;
         mismatched++;
         $display("FAIL stall_sender: got sender stuck, want all 12 symbols sent");
      end
      do_flush();
      drain();
      chk("bit_count_stall", bus.bit_count, 32'd98);

      // Unmapped symbol 'A' (0x41).
`ifdef HUFF_ESCAPE_EN
      expect_word(8'h01, 4'd8, 1'b0);
      expect_word(8'h04, 4'd6, 1'b1);
      exp_bc = 32'd112;
`else
      expect_word(8'h00, 4'd0, 1'b1);
      exp_bc = 32'd98;
`endif
      send(8'h41);
      chk("err_sym_pulse", 32'(bus.err_sym), 32'd1);
      tick();
      chk("err_sym_clear", 32'(bus.err_sym), 32'd0);
      do_flush();
      drain();
      chk("bit_count_unmapped", bus.bit_count, exp_bc);

      // Reset while in FLUSH with 5 bits ('r' = 00100) buffered.
      bus.out_ready = 1'b0;
      send(8'h72);
      do_flush();
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_out_last",  32'(bus.out_last),  32'd0);
      chk("midrst_out_bits",  32'(bus.out_bits),  32'd0);
      chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("midrst_bit_count", bus.bit_count,      32'd0);
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("postrst_in_ready",  32'(bus.in_ready),  32'd1);
      expect_word(8'hE0, 4'd3, 1'b1);
      send(8'h20);
      do_flush();
      drain();
      chk("bit_count_postrst", bus.bit_count, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/huffman_packer.md
HUFFMAN_PACKER -- requirements
Module: huffman_packer

Interface
REQ-001 Parameter OUT_W, default 32, output word width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter MAX_LEN, default 14, longest emitted code in bits, escape sequence included; legal range 14..24.
REQ-003 clk  input  1  clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  ASCII symbol to encode.
REQ-006 in_valid / in_ready  input / output  1 each  symbol handshake; a symbol transfers when both are high at a rising edge.
REQ-007 flush  input  1  single-cycle request to terminate the current stream.
REQ-008 out_data  output  OUT_W  packed code bits; the first stream bit is in the MSB.
REQ-009 out_valid / out_ready  output / input  1 each  word handshake; a word transfers when both are high.
REQ-010 out_last  output  1  high on the final word of a stream.
REQ-011 out_bits  output  clog2(OUT_W+1)  number of valid bits in out_data: OUT_W, or fewer on the last word.
REQ-012 err_sym  output  1  one-cycle pulse when an unmapped symbol is accepted.
REQ-013 bit_count  output  32  total code bits accepted since reset; wraps modulo 2^32.

Function
REQ-014 Code table: a-z and space (0x20) map to prefix-free codes defined in the package; fixed entries: space = 3'b111 (len 3); 'e' = 4'b0110 (len 4); escape prefix = 6'b000000 (len 6).
REQ-015 Accumulator width = OUT_W + MAX_LEN; fill counter range 0..OUT_W+MAX_LEN-1; each accepted code is appended MSB-first directly after the currently filled bits.
REQ-016 States: RUN, FLUSH, LAST; reset state is RUN.
REQ-017 in_ready = 1 only when state == RUN and fill < OUT_W.
REQ-018 In RUN and FLUSH, out_valid = 1 when fill >= OUT_W, with out_data = top OUT_W accumulator bits, out_bits = OUT_W, out_last = 0.
REQ-019 On a word transfer, the accumulator shifts left by OUT_W and fill decreases by OUT_W.
REQ-020 When a symbol and a word transfer in the same cycle, next fill = fill - OUT_W + len, and the new code is placed correctly after the shift.
REQ-021 Latency: a symbol accepted at edge N is in the accumulator after N; the earliest out_valid for it is the cycle after N.
REQ-022 flush sampled high in RUN moves the FSM to FLUSH; a symbol accepted on the same edge is included in the stream before termination.
REQ-023 FLUSH moves to LAST when fill < OUT_W.
REQ-024 In LAST: out_valid = 1, out_last = 1, out_bits = fill (0 is legal), out_data = remaining bits with zero padding below them.
REQ-025 A word transfer in LAST clears the accumulator and fill and returns the FSM to RUN.
REQ-026 flush in FLUSH or LAST is ignored.
REQ-027 While out_ready is low, out_data, out_valid, out_bits and out_last hold stable.
REQ-028 bit_count increments by len for every accepted symbol, escape bits included when escape is enabled.

Reset
REQ-029 While rst is high: state = RUN, accumulator = 0, fill = 0, out_valid = 0, out_last = 0, out_bits = 0, err_sym = 0, bit_count = 0, in_ready = 1.
REQ-030 Reset asserted mid-stream discards all buffered bits with no partial word emitted; after reset release the first cycle accepts input.

Configuration
REQ-031 Macro HUFF_ESCAPE_EN defined: an unmapped symbol is emitted as the escape prefix followed by the 8 raw bits (len 14), and err_sym is still pulsed.
REQ-032 Macro HUFF_ESCAPE_EN undefined: an unmapped symbol is accepted and dropped with no bits and no bit_count change, and err_sym is pulsed.

Structure
REQ-033 Package huff_pkg holds: code and length constants for all 27 symbols; escape prefix and length; the FSM state enum; and the MAX_LEN lower bound 14.
REQ-034 Sub-module huff_code_lut is combinational: symbol in; code, length and unmapped flag out. The packer instantiates it exactly once.

Verification
REQ-035 OUT_W=8: 8 x space with out_ready=1 -> 24 bits; words 0xFF, 0xFF, 0xFF; bit_count=24.
REQ-036 OUT_W=8: "e", space, then flush -> one last word 0x6E with out_bits=7 and out_last=1.
REQ-037 flush with empty accumulator -> a single word with out_last=1, out_bits=0, out_data=0.
REQ-038 out_ready held low for 20 cycles under continuous input -> in_ready drops, no word lost or changed, and the stream resumes intact.
REQ-039 Symbol 0x41 with HUFF_ESCAPE_EN defined -> 14 bits 000000_01000001, err_sym pulse; without the macro -> no bits, err_sym pulse, bit_count unchanged.
REQ-040 Reset asserted during FLUSH with 5 bits buffered -> no out_last word; outputs equal reset values the next cycle.
